sys_arr_feed_ctrl: RTL and testbench
====================================

Name: sys_arr_feed_ctrl

Overview:
Sequences one tile of input vectors into the systolic-array skew bank, a set of per-row delay chains sharing one clock enable. Accepts vectors from the upstream buffer via valid/ready and drives the shared chain_clk_en and valid. After the last vector it flushes the skew/deskew pipeline with bubbles, then pulses tile_done. Sits between the tile scheduler and the skew delay-chain bank.

Parameters:
ARR_DIM, 8, systolic array dimension; sets the default drain length.
DRAIN_CYC, 2*ARR_DIM-1, advancing cycles required to empty skew plus deskew chains after the last vector; 0 is legal.
TILE_LEN_WDT, 16, width of the tile length and vector counter.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
tile_start  input  1  start request; sampled only in IDLE.
tile_len  input  TILE_LEN_WDT  vectors in the tile; latched with tile_start.
tile_abort  input  1  stops loading early; honoured only in LOAD.
tile_busy  output  1  high in LOAD, DRAIN and DONE.
tile_done  output  1  one-cycle completion pulse.
in_val  input  1  upstream vector valid.
in_rdy  output  1  upstream ready; transfer = in_val && in_rdy.
out_rdy  input  1  array can advance this cycle; low stalls the whole bank.
chain_clk_en  output  1  shared clock enable to all skew delay chains.
chain_in_val  output  1  valid bit injected at the head of the chains.
chain_flush  output  1  selects zero data at the chain heads.
vec_cnt  output  TILE_LEN_WDT  vectors accepted in the current tile.

Behaviour:
- Synchronous, active-high reset (rst=1 at a rising edge): state=IDLE; vec_cnt=0; drain counter=0; latched length=0.
- While rst is high, in_rdy, chain_in_val, chain_clk_en, chain_flush, tile_busy and tile_done are all 0.
- FSM states: IDLE, LOAD, DRAIN, DONE. tile_busy and tile_done decode from state. in_rdy, chain_in_val and chain_clk_en are combinational from state, in_val and out_rdy.
- chain_clk_en = out_rdy in every state, so a stall freezes the whole chain bank, including residual data in IDLE.
- IDLE:
  - in_rdy=0, chain_in_val=0.
  - tile_start with tile_len!=0: latch length, clear vec_cnt, go to LOAD.
  - tile_start with tile_len==0: go to DONE.
- LOAD:
  - in_rdy = out_rdy; chain_in_val = in_val && out_rdy.
  - Each transfer increments vec_cnt.
  - If out_rdy=1 and in_val=0, the chain advances with chain_in_val=0 (a bubble).
  - A transfer with vec_cnt == length-1 goes to DRAIN, or to DONE if DRAIN_CYC==0.
  - tile_abort goes to DRAIN (or DONE) next cycle. A transfer in the same cycle still counts.
- DRAIN:
  - in_rdy=0, chain_in_val=0, chain_flush=1.
  - The drain counter increments only when out_rdy=1.
  - When drain counter == DRAIN_CYC-1 and out_rdy=1: go to DONE and clear the counter.
- DONE: tile_done=1 for exactly one cycle, in_rdy=0, then IDLE unconditionally.
- tile_start outside IDLE is ignored, not queued. tile_len changes outside IDLE have no effect.
- vec_cnt holds its final value through DONE and IDLE until the next accepted tile_start.
- Counter widths: vec_cnt never wraps, since it stops at length. The drain counter is $clog2(DRAIN_CYC+1) bits.
- Reset mid-operation: return to IDLE next cycle, no tile_done, all counters cleared.

Test Plan:
All scenarios use ARR_DIM=4, DRAIN_CYC=7; tile_start is high in cycle 0.
1. tile_len=3, in_val=1, out_rdy=1 throughout -> LOAD cycles 1-3 with chain_in_val=1 and vec_cnt reaching 3; DRAIN cycles 4-10 with chain_flush=1; tile_done only in cycle 11; tile_busy high in cycles 1-11.
2. Same as 1, but out_rdy=0 in cycles 2-3 -> chain_clk_en=0, in_rdy=0 and vec_cnt=1 frozen in cycles 2-3; tile_done moves to cycle 13. Also drop out_rdy for 1 cycle inside DRAIN -> tile_done one cycle later again.
3. tile_len=2, in_val=0 in cycle 1, 1 afterwards -> cycle 1 chain_clk_en=1 and chain_in_val=0 (bubble); transfers in cycles 2-3; DRAIN starts in cycle 4; tile_done in cycle 11.
4. tile_len=0 -> DONE in cycle 1, tile_done=1 in cycle 1, chain_in_val never asserted, IDLE in cycle 2.
5. tile_len=5, rst=1 in cycle 3 -> from cycle 4 all outputs 0 and vec_cnt=0; tile_done never pulses; a new tile_start with tile_len=1 after rst deasserts completes normally.
6. tile_len=10, tile_abort in cycle 2 together with a transfer -> vec_cnt=2, DRAIN in cycles 3-9, tile_done in cycle 10. A tile_start in cycle 5 is ignored.

Source files
------------

// File: rtl/sys_arr_feed_ctrl.sv
// Feed controller for the systolic-array skew bank: loads one tile of vectors
// through valid/ready, flushes the skew/deskew chains with bubbles, then pulses tile_done.
module sys_arr_feed_ctrl #(
  parameter int ARR_DIM      = 8,
  parameter int DRAIN_CYC    = 2 * ARR_DIM - 1,
  parameter int TILE_LEN_WDT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tile_start,
  input  logic [TILE_LEN_WDT-1:0] tile_len,
  input  logic                    tile_abort,
  output logic                    tile_busy,
  output logic                    tile_done,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic                    out_rdy,
  output logic                    chain_clk_en,
  output logic                    chain_in_val,
  output logic                    chain_flush,
  output logic [TILE_LEN_WDT-1:0] vec_cnt
);

  // A zero-length drain still needs a 1-bit counter to keep the declaration legal.
  localparam int DCW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [TILE_LEN_WDT-1:0] len_r;
  logic [TILE_LEN_WDT-1:0] vec_cnt_r;
  logic [DCW-1:0]          drain_cnt_r;
  logic                    xfer_s;

  assign vec_cnt = vec_cnt_r;

  // Output decode: everything held low during reset, otherwise derived from state and handshakes.
  always_comb begin
    in_rdy       = 1'b0;
    chain_in_val = 1'b0;
    chain_clk_en = 1'b0;
    chain_flush  = 1'b0;
    tile_busy    = 1'b0;
    tile_done    = 1'b0;
    if (rst) begin
      chain_clk_en = 1'b0;
    end else begin
      chain_clk_en = out_rdy;
      case (state_r)
        LOAD: begin
          in_rdy       = out_rdy;
          chain_in_val = in_val && out_rdy;
          tile_busy    = 1'b1;
        end
        DRAIN: begin
          chain_flush = 1'b1;
          tile_busy   = 1'b1;
        end
        DONE: begin
          tile_busy = 1'b1;
          tile_done = 1'b1;
        end
        default: begin
          tile_busy = 1'b0;
        end
      endcase
    end
  end

  assign xfer_s = in_val && in_rdy;

  // Tile sequencer: state, vector counter, latched length and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      len_r       <= TILE_LEN_WDT'(0);
      vec_cnt_r   <= TILE_LEN_WDT'(0);
      drain_cnt_r <= DCW'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (tile_start) begin
            if (tile_len != TILE_LEN_WDT'(0)) begin
              len_r     <= tile_len;
              vec_cnt_r <= TILE_LEN_WDT'(0);
              state_r   <= LOAD;
            end else begin
              state_r <= DONE;
            end
          end
        end
        LOAD: begin
          if (xfer_s) begin
            vec_cnt_r <= vec_cnt_r + TILE_LEN_WDT'(1);
          end
          // An abort still lets a same-cycle transfer count before leaving.
          if ((xfer_s && (vec_cnt_r == len_r - TILE_LEN_WDT'(1))) || tile_abort) begin
            if (DRAIN_CYC == 0) begin
              state_r <= DONE;
            end else begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_rdy) begin
            if (drain_cnt_r == DRAIN_LAST) begin
              drain_cnt_r <= DCW'(0);
              state_r     <= DONE;
            end else begin
              drain_cnt_r <= drain_cnt_r + DCW'(1);
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_arr_feed_ctrl.sv
// Self-checking bench for sys_arr_feed_ctrl: directed tile scenarios plus random
// traffic, compared each cycle against a counter-based tile model.
module tb_sys_arr_feed_ctrl;

  localparam int DR = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tile_start = 1'b0;
  logic [15:0] tile_len = 16'd0;
  logic        tile_abort = 1'b0;
  logic        tile_busy, tile_done;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic        out_rdy = 1'b0;
  logic        chain_clk_en, chain_in_val, chain_flush;
  logic [15:0] vec_cnt;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int done_at  = -1;

  // Tile model: vectors still to load, advancing cycles still to drain, pending done pulse.
  bit m_loading = 1'b0;
  int m_left    = 0;
  int m_drain   = 0;
  bit m_done    = 1'b0;
  int m_cnt     = 0;

  sys_arr_feed_ctrl #(.ARR_DIM(4), .DRAIN_CYC(DR), .TILE_LEN_WDT(16)) dut (
    .clk(clk), .rst(rst), .tile_start(tile_start), .tile_len(tile_len),
    .tile_abort(tile_abort), .tile_busy(tile_busy), .tile_done(tile_done),
    .in_val(in_val), .in_rdy(in_rdy), .out_rdy(out_rdy),
    .chain_clk_en(chain_clk_en), .chain_in_val(chain_in_val),
    .chain_flush(chain_flush), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, compare all outputs against the model, then advance the model.
  task automatic cycle(input bit st, input int len, input bit ab, input bit iv,
                       input bit ordy, input bit rs);
    bit e_busy, e_done, e_flush, e_rdy, e_civ, e_en;
    @(negedge clk);
    tile_start = st; tile_len = len[15:0]; tile_abort = ab;
    in_val = iv; out_rdy = ordy; rst = rs;
    #2;
    e_busy  = !rs && (m_loading || m_drain > 0 || m_done);
    e_done  = !rs && m_done;
    e_flush = !rs && m_drain > 0;
    e_rdy   = !rs && m_loading && ordy;
    e_civ   = e_rdy && iv;
    e_en    = !rs && ordy;
    check_val("tile_busy", {31'd0, tile_busy}, {31'd0, e_busy});
    check_val("tile_done", {31'd0, tile_done}, {31'd0, e_done});
    check_val("chain_flush", {31'd0, chain_flush}, {31'd0, e_flush});
    check_val("in_rdy", {31'd0, in_rdy}, {31'd0, e_rdy});
    check_val("chain_in_val", {31'd0, chain_in_val}, {31'd0, e_civ});
    check_val("chain_clk_en", {31'd0, chain_clk_en}, {31'd0, e_en});
    check_val("vec_cnt", {16'd0, vec_cnt}, m_cnt);
    if (tile_done === 1'b1 && done_at < 0) done_at = cyc;
    cyc++;
    if (rs) begin
      m_loading = 1'b0; m_left = 0; m_drain = 0; m_done = 1'b0; m_cnt = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_drain > 0) begin
      if (ordy) begin
        m_drain--;
        if (m_drain == 0) m_done = 1'b1;
      end
    end else if (m_loading) begin
      if (iv && ordy) begin
        m_cnt++;
        m_left--;
      end
      if (m_left == 0 || ab) begin
        m_loading = 1'b0;
        if (DR == 0) m_done = 1'b1;
        else m_drain = DR;
      end
    end else if (st) begin
      if (len != 0) begin
        m_loading = 1'b1; m_left = len; m_cnt = 0;
      end else begin
        m_done = 1'b1;
      end
    end
  endtask

  // Directed tile: cycle 0 starts a tile of len; bit c of a mask affects cycle c.
  task automatic scen(input string name, input int len, input int len2,
                      input logic [31:0] stall, input logic [31:0] bubble,
                      input int abort_c, input int rst_c, input int start_c,
                      input int exp_done, input int exp_cnt);
    cyc = 0;
    done_at = -1;
    for (int c = 0; c < 24; c++) begin
      cycle(c == 0 || c == start_c, (c == 0) ? len : len2, c == abort_c,
            !bubble[c], !stall[c], c == rst_c);
    end
    check_val({name, "_done_cycle"}, done_at, exp_done);
    check_val({name, "_final_vec_cnt"}, {16'd0, vec_cnt}, exp_cnt);
  endtask

  initial begin
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("reset_vec_cnt", {16'd0, vec_cnt}, 32'd0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    scen("t1_basic",  3,  3, 32'h0, 32'h0, -1, -1, -1, 11, 3);
    scen("t2_stall",  3,  3, (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 8), 32'h0,
         -1, -1, -1, 14, 3);
    scen("t3_bubble", 2,  2, 32'h0, 32'd1 << 1, -1, -1, -1, 11, 2);
    scen("t4_zero",   0,  0, 32'h0, 32'h0, -1, -1, -1, 1, 2);
    scen("t5_reset",  5,  1, 32'h0, 32'h0, -1, 3, 6, 15, 1);
    scen("t6_abort", 10,  4, 32'h0, 32'h0, 2, -1, 5, 10, 2);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 12), $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
